// File: rtl/iq_fetch_ctrl_pkg.sv
// Shared constants for the fetch-side scheduler and the instruction queue:
// reset PC, fetch block size, IQ sizing, FSM encoding and redirect-select encoding.
package iq_fetch_ctrl_pkg;

    // First fetch address after reset.
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;

    // One fetch returns a 16-byte block, i.e. four 32-bit instructions,
    // so every in-flight fetch may occupy up to four IQ entries.
    localparam int unsigned FETCH_BYTES     = 16;
    localparam int unsigned SLOTS_PER_FETCH = FETCH_BYTES / 4;

    // Instruction-queue sizing, shared with the queue itself.
    localparam int unsigned IQ_CAP_DEF  = 16;
    localparam int unsigned IQ_GAP_DEF  = 1;
    localparam int unsigned MAX_OUT_DEF = 2;

    // Scheduler FSM encoding.
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Redirect source select, highest priority first.
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_EXC  = 2'd1;
    localparam logic [1:0] SEL_SBA  = 2'd2;
    localparam logic [1:0] SEL_PRED = 2'd3;

    // Start of the next sequential 16-byte fetch block.
    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
        return {pc[31:4] + 28'd1, 4'b0000};
    endfunction

endpackage

// File: rtl/iq_credit_calc.sv
// Combinational credit check: may one more 16-byte fetch be launched without
// risking IQ overflow, given current occupancy and fetches already in flight.
module iq_credit_calc
    import iq_fetch_ctrl_pkg::*;
#(
    parameter int unsigned IQ_CAP  = IQ_CAP_DEF,
    parameter int unsigned IQ_GAP  = IQ_GAP_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF,
    parameter int unsigned IQ_W    = $clog2(IQ_CAP) + 1,
    parameter int unsigned OUT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic [IQ_W-1:0]  iq_number,
    input  logic [OUT_W-1:0] outstanding,
    output logic             credit_ok
);

    // Wide enough that occupancy + 4*outstanding + 4 never wraps.
    localparam int unsigned CW = IQ_W + OUT_W + 2;

    logic [CW-1:0] need;
    logic [CW-1:0] limit;

    // Reserve a full block for every in-flight fetch plus the candidate one.
    always_comb begin
        need      = CW'(iq_number) + CW'(outstanding) * CW'(SLOTS_PER_FETCH)
                    + CW'(SLOTS_PER_FETCH);
        limit     = CW'(IQ_CAP - IQ_GAP);
        credit_ok = (32'(outstanding) < MAX_OUT) && (need <= limit);
    end

endmodule

// File: rtl/iq_fetch_ctrl.sv
// Fetch-side scheduler for the instruction queue: launches credit-checked
// sequential fetches, redirects on flush/exception/predicted-taken, and
// squashes stale in-flight responses before they reach the IQ.
module iq_fetch_ctrl
    import iq_fetch_ctrl_pkg::*;
#(
    parameter int unsigned IQ_CAP   = IQ_CAP_DEF,
    parameter int unsigned IQ_GAP   = IQ_GAP_DEF,
    parameter int unsigned MAX_OUT  = MAX_OUT_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned IQ_W     = $clog2(IQ_CAP) + 1,
    parameter int unsigned OUT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SBA_flush_w_i,
    input  logic [31:0]      SBA_flushPC_i,
    input  logic             CP0_excOccur_w_i,
    input  logic [31:0]      CP0_excPC_i,
    input  logic [IQ_W-1:0]  IQ_number_w,
    output logic             fetchReq_valid_o,
    input  logic             fetchReq_ready_i,
    output logic [31:0]      fetchReq_PC_o,
    input  logic             IF_respValid_i,
    input  logic             IF_predRedirect_i,
    input  logic [31:0]      IF_predTarget_i,
    output logic             IQ_writeValid_o,
    output logic [OUT_W-1:0] IF_outstanding_o
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] drop_q, drop_d;

    logic       flush_any;
    logic       credit_ok;
    logic       fire;
    logic       keep;
    logic [1:0] sel;

    iq_credit_calc #(
        .IQ_CAP  (IQ_CAP),
        .IQ_GAP  (IQ_GAP),
        .MAX_OUT (MAX_OUT),
        .IQ_W    (IQ_W),
        .OUT_W   (OUT_W)
    ) u_credit (
        .iq_number   (IQ_number_w),
        .outstanding (out_q),
        .credit_ok   (credit_ok)
    );

    // Request valid, accept, and response keep/squash decisions.
    always_comb begin
        flush_any        = CP0_excOccur_w_i || SBA_flush_w_i;
        fetchReq_valid_o = (state_q != ST_BOOT) && !flush_any && credit_ok;
        fire             = fetchReq_valid_o && fetchReq_ready_i;
        keep             = IF_respValid_i && (drop_q == '0) && !flush_any;
        IQ_writeValid_o  = keep;
    end

    // Redirect source, exception over branch flush over predicted-taken.
    always_comb begin
        sel = SEL_NONE;
        if (CP0_excOccur_w_i) begin
            sel = SEL_EXC;
        end else if (SBA_flush_w_i) begin
            sel = SEL_SBA;
        end else if (keep && IF_predRedirect_i) begin
            sel = SEL_PRED;
        end
    end

    // Next PC, in-flight count, drop count and FSM state.
    always_comb begin
        out_d  = out_q + OUT_W'(fire) - OUT_W'(IF_respValid_i);
        pc_d   = pc_q;
        drop_d = drop_q;
        unique case (sel)
            SEL_EXC: begin
                pc_d   = CP0_excPC_i;
                // Every older in-flight response is wrong-path.
                drop_d = out_q - OUT_W'(IF_respValid_i);
            end
            SEL_SBA: begin
                pc_d   = SBA_flushPC_i;
                drop_d = out_q - OUT_W'(IF_respValid_i);
            end
            SEL_PRED: begin
                pc_d   = IF_predTarget_i;
                // Younger in-flight fetches, including one accepted now, follow the wrong path.
                drop_d = out_q - OUT_W'(1) + OUT_W'(fire);
            end
            default: begin
                if (fire) begin
                    pc_d = next_fetch_pc(pc_q);
                end
                if (IF_respValid_i && (drop_q != '0)) begin
                    drop_d = drop_q - OUT_W'(1);
                end
            end
        endcase
        // BOOT always lasts one cycle; afterwards the drop count selects RUN/DRAIN.
        state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    // Registered outputs.
    always_comb begin
        fetchReq_PC_o    = pc_q;
        IF_outstanding_o = out_q;
    end

endmodule

// File: tb/tb_iq_fetch_ctrl.sv
// Self-checking bench for iq_fetch_ctrl: directed scenarios plus randomized
// traffic checked against a queue-of-in-flight-fetches reference model.
module tb_iq_fetch_ctrl;

    localparam int IQ_CAP  = 16;
    localparam int IQ_GAP  = 1;
    localparam int MAX_OUT = 2;
    localparam int IQ_W    = 5;
    localparam int OUT_W   = 2;
    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic             clk;
    logic             rst;
    logic             SBA_flush_w_i;
    logic [31:0]      SBA_flushPC_i;
    logic             CP0_excOccur_w_i;
    logic [31:0]      CP0_excPC_i;
    logic [IQ_W-1:0]  IQ_number_w;
    logic             fetchReq_valid_o;
    logic             fetchReq_ready_i;
    logic [31:0]      fetchReq_PC_o;
    logic             IF_respValid_i;
    logic             IF_predRedirect_i;
    logic [31:0]      IF_predTarget_i;
    logic             IQ_writeValid_o;
    logic [OUT_W-1:0] IF_outstanding_o;

    iq_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .SBA_flush_w_i     (SBA_flush_w_i),
        .SBA_flushPC_i     (SBA_flushPC_i),
        .CP0_excOccur_w_i  (CP0_excOccur_w_i),
        .CP0_excPC_i       (CP0_excPC_i),
        .IQ_number_w       (IQ_number_w),
        .fetchReq_valid_o  (fetchReq_valid_o),
        .fetchReq_ready_i  (fetchReq_ready_i),
        .fetchReq_PC_o     (fetchReq_PC_o),
        .IF_respValid_i    (IF_respValid_i),
        .IF_predRedirect_i (IF_predRedirect_i),
        .IF_predTarget_i   (IF_predTarget_i),
        .IQ_writeValid_o   (IQ_writeValid_o),
        .IF_outstanding_o  (IF_outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one entry per in-flight fetch, flagged if its response is stale.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          q[$];
    bit          exp_valid, exp_wv, m_fire, m_keep;
    logic [31:0] exp_pc;
    logic [1:0]  exp_out;

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = RESET_PC;
        q.delete();
    endtask

    task automatic model_comb();
        bit flush;
        int need;
        flush     = CP0_excOccur_w_i || SBA_flush_w_i;
        need      = int'(IQ_number_w) + 4 * q.size() + 4;
        exp_valid = !m_boot && !flush && (q.size() < MAX_OUT) && (need <= IQ_CAP - IQ_GAP);
        m_fire    = exp_valid && fetchReq_ready_i;
        m_keep    = IF_respValid_i && (q.size() > 0) && !q[0] && !flush;
        exp_wv    = m_keep;
        exp_pc    = m_pc;
        exp_out   = 2'(q.size());
    endtask

    task automatic model_commit();
        bit flush;
        bit pred;
        flush = CP0_excOccur_w_i || SBA_flush_w_i;
        pred  = m_keep && IF_predRedirect_i;
        if (IF_respValid_i) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL model_underflow: response with nothing in flight");
            end else begin
                void'(q.pop_front());
            end
        end
        if (CP0_excOccur_w_i)   m_pc = CP0_excPC_i;
        else if (SBA_flush_w_i) m_pc = SBA_flushPC_i;
        else if (pred)          m_pc = IF_predTarget_i;
        else if (m_fire)        m_pc = (m_pc & ~32'hF) + 32'd16;
        if (flush || pred) begin
            foreach (q[i]) q[i] = 1'b1;
        end
        if (m_fire) q.push_back(pred);
        m_boot = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_comb();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic quiet();
        SBA_flush_w_i     = 1'b0;
        SBA_flushPC_i     = '0;
        CP0_excOccur_w_i  = 1'b0;
        CP0_excPC_i       = '0;
        IQ_number_w       = '0;
        fetchReq_ready_i  = 1'b0;
        IF_respValid_i    = 1'b0;
        IF_predRedirect_i = 1'b0;
        IF_predTarget_i   = '0;
    endtask

    // A response must never arrive with nothing in flight.
    always @(negedge clk) begin
        if (!rst && IF_respValid_i) begin
            n_checks++;
            if (IF_outstanding_o == '0) $display("FAIL illegal_resp: outstanding got 0 want >0");
            else n_pass++;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (fetchReq_valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", fetchReq_valid_o); else n_pass++;
        n_checks++; if (fetchReq_PC_o !== RESET_PC) $display("FAIL rst_pc got %h want %h", fetchReq_PC_o, RESET_PC); else n_pass++;
        n_checks++; if (IQ_writeValid_o !== 1'b0) $display("FAIL rst_wv got %0b want 0", IQ_writeValid_o); else n_pass++;
        n_checks++; if (IF_outstanding_o !== 2'd0) $display("FAIL rst_out got %0d want 0", IF_outstanding_o); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_boot_stream();
        fetchReq_ready_i = 1'b1;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b0) $display("FAIL boot_valid got %0b want 0", fetchReq_valid_o); else n_pass++;
        advance();
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b1) $display("FAIL stream0_valid got %0b want 1", fetchReq_valid_o); else n_pass++;
        n_checks++; if (fetchReq_PC_o !== 32'hBFC00000) $display("FAIL stream0_pc got %h want bfc00000", fetchReq_PC_o); else n_pass++;
        advance();
        settle();
        n_checks++; if (fetchReq_PC_o !== 32'hBFC00010) $display("FAIL stream1_pc got %h want bfc00010", fetchReq_PC_o); else n_pass++;
        n_checks++; if (IF_outstanding_o !== 2'd1) $display("FAIL stream1_out got %0d want 1", IF_outstanding_o); else n_pass++;
        advance();
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b0) $display("FAIL stream_full_valid got %0b want 0", fetchReq_valid_o); else n_pass++;
        n_checks++; if (IF_outstanding_o !== 2'd2) $display("FAIL stream_full_out got %0d want 2", IF_outstanding_o); else n_pass++;
        advance();
        fetchReq_ready_i = 1'b0;
        IF_respValid_i   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++; if (IQ_writeValid_o !== 1'b1) $display("FAIL stream_resp%0d_wv got %0b want 1", i, IQ_writeValid_o); else n_pass++;
            advance();
        end
        IF_respValid_i = 1'b0;
    endtask

    task automatic test_credit();
        fetchReq_ready_i = 1'b1;
        IQ_number_w      = 5'd8;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b1) $display("FAIL credit_iq8_out0 got %0b want 1", fetchReq_valid_o); else n_pass++;
        advance();
        fetchReq_ready_i = 1'b0;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b0) $display("FAIL credit_iq8_out1 got %0b want 0", fetchReq_valid_o); else n_pass++;
        advance();
        IQ_number_w = 5'd7;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b1) $display("FAIL credit_iq7_out1 got %0b want 1", fetchReq_valid_o); else n_pass++;
        advance();
        IQ_number_w    = '0;
        IF_respValid_i = 1'b1;
        settle();
        advance();
        IF_respValid_i = 1'b0;
    endtask

    task automatic test_exc_flush();
        fetchReq_ready_i = 1'b1;
        repeat (2) begin
            settle();
            advance();
        end
        fetchReq_ready_i = 1'b0;
        CP0_excOccur_w_i = 1'b1;
        CP0_excPC_i      = 32'hBFC00380;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b0) $display("FAIL exc_valid got %0b want 0", fetchReq_valid_o); else n_pass++;
        advance();
        CP0_excOccur_w_i = 1'b0;
        IF_respValid_i   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++; if (IQ_writeValid_o !== 1'b0) $display("FAIL exc_drop%0d_wv got %0b want 0", i, IQ_writeValid_o); else n_pass++;
            advance();
        end
        IF_respValid_i   = 1'b0;
        fetchReq_ready_i = 1'b1;
        settle();
        n_checks++; if (fetchReq_PC_o !== 32'hBFC00380) $display("FAIL exc_newpc got %h want bfc00380", fetchReq_PC_o); else n_pass++;
        n_checks++; if (fetchReq_valid_o !== 1'b1) $display("FAIL exc_newvalid got %0b want 1", fetchReq_valid_o); else n_pass++;
        advance();
        fetchReq_ready_i = 1'b0;
        IF_respValid_i   = 1'b1;
        settle();
        n_checks++; if (IQ_writeValid_o !== 1'b1) $display("FAIL exc_keep_wv got %0b want 1", IQ_writeValid_o); else n_pass++;
        advance();
        IF_respValid_i = 1'b0;
    endtask

    task automatic test_pred();
        fetchReq_ready_i = 1'b1;
        settle();
        advance();
        IF_respValid_i    = 1'b1;
        IF_predRedirect_i = 1'b1;
        IF_predTarget_i   = 32'h80001000;
        settle();
        n_checks++; if (IQ_writeValid_o !== 1'b1) $display("FAIL pred_wv got %0b want 1", IQ_writeValid_o); else n_pass++;
        n_checks++; if (fetchReq_valid_o !== 1'b1) $display("FAIL pred_fire_valid got %0b want 1", fetchReq_valid_o); else n_pass++;
        advance();
        IF_predRedirect_i = 1'b0;
        fetchReq_ready_i  = 1'b0;
        settle();
        n_checks++; if (fetchReq_PC_o !== 32'h80001000) $display("FAIL pred_pc got %h want 80001000", fetchReq_PC_o); else n_pass++;
        n_checks++; if (IF_outstanding_o !== 2'd1) $display("FAIL pred_out got %0d want 1", IF_outstanding_o); else n_pass++;
        n_checks++; if (IQ_writeValid_o !== 1'b0) $display("FAIL pred_drop_wv got %0b want 0", IQ_writeValid_o); else n_pass++;
        advance();
        IF_respValid_i = 1'b0;
    endtask

    task automatic test_dual_flush();
        fetchReq_ready_i = 1'b1;
        CP0_excOccur_w_i = 1'b1;
        CP0_excPC_i      = 32'h90000100;
        SBA_flush_w_i    = 1'b1;
        SBA_flushPC_i    = 32'h90000200;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b0) $display("FAIL dual_valid got %0b want 0", fetchReq_valid_o); else n_pass++;
        advance();
        CP0_excOccur_w_i = 1'b0;
        SBA_flush_w_i    = 1'b0;
        fetchReq_ready_i = 1'b0;
        settle();
        n_checks++; if (fetchReq_PC_o !== 32'h90000100) $display("FAIL dual_pc got %h want 90000100", fetchReq_PC_o); else n_pass++;
        advance();
    endtask

    task automatic test_stall();
        fetchReq_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_checks++; if (fetchReq_valid_o !== 1'b1) $display("FAIL stall%0d_valid got %0b want 1", i, fetchReq_valid_o); else n_pass++;
            n_checks++; if (fetchReq_PC_o !== 32'h90000100) $display("FAIL stall%0d_pc got %h want 90000100", i, fetchReq_PC_o); else n_pass++;
            n_checks++; if (IF_outstanding_o !== 2'd0) $display("FAIL stall%0d_out got %0d want 0", i, IF_outstanding_o); else n_pass++;
            advance();
        end
        fetchReq_ready_i = 1'b1;
        settle();
        advance();
        fetchReq_ready_i = 1'b0;
        settle();
        n_checks++; if (fetchReq_PC_o !== 32'h90000110) $display("FAIL stall_rel_pc got %h want 90000110", fetchReq_PC_o); else n_pass++;
        n_checks++; if (IF_outstanding_o !== 2'd1) $display("FAIL stall_rel_out got %0d want 1", IF_outstanding_o); else n_pass++;
        advance();
        IF_respValid_i = 1'b1;
        settle();
        advance();
        IF_respValid_i = 1'b0;
    endtask

    task automatic test_flush_boot();
        rst = 1'b1;
        quiet();
        model_reset();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        SBA_flush_w_i = 1'b1;
        SBA_flushPC_i = 32'h12345670;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b0) $display("FAIL bootflush_valid got %0b want 0", fetchReq_valid_o); else n_pass++;
        advance();
        SBA_flush_w_i    = 1'b0;
        fetchReq_ready_i = 1'b1;
        settle();
        n_checks++; if (fetchReq_valid_o !== 1'b1) $display("FAIL bootflush_run_valid got %0b want 1", fetchReq_valid_o); else n_pass++;
        n_checks++; if (fetchReq_PC_o !== 32'h12345670) $display("FAIL bootflush_pc got %h want 12345670", fetchReq_PC_o); else n_pass++;
        advance();
        fetchReq_ready_i = 1'b0;
        IF_respValid_i   = 1'b1;
        settle();
        advance();
        IF_respValid_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            IQ_number_w       = 5'($urandom_range(0, 16));
            fetchReq_ready_i  = ($urandom_range(0, 3) != 0);
            IF_respValid_i    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            IF_predRedirect_i = ($urandom_range(0, 3) == 0);
            IF_predTarget_i   = $urandom;
            CP0_excOccur_w_i  = ($urandom_range(0, 19) == 0);
            CP0_excPC_i       = $urandom;
            SBA_flush_w_i     = ($urandom_range(0, 19) == 0);
            SBA_flushPC_i     = $urandom;
            settle();
            n_checks++; if (fetchReq_valid_o !== exp_valid) $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, fetchReq_valid_o, exp_valid); else n_pass++;
            n_checks++; if (fetchReq_PC_o !== exp_pc) $display("FAIL rnd_pc cyc %0d got %h want %h", i, fetchReq_PC_o, exp_pc); else n_pass++;
            n_checks++; if (IQ_writeValid_o !== exp_wv) $display("FAIL rnd_wv cyc %0d got %0b want %0b", i, IQ_writeValid_o, exp_wv); else n_pass++;
            n_checks++; if (IF_outstanding_o !== exp_out) $display("FAIL rnd_out cyc %0d got %0d want %0d", i, IF_outstanding_o, exp_out); else n_pass++;
            advance();
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_boot_stream();
        test_credit();
        test_exc_flush();
        test_pred();
        test_dual_flush();
        test_stall();
        test_flush_boot();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/iq_fetch_ctrl.md
Name: iq_fetch_ctrl

Overview:
Fetch-side scheduler for the instruction queue. It decides each cycle whether IF may launch a new 16-byte fetch, based on queue occupancy plus credit reserved for in-flight fetches, and generates the sequential fetch PC. It squashes stale in-flight responses after a flush, exception or predicted-taken redirect, and gates the IQ write strobe. It sits between the PC/IF stage and the instruction queue in ID.

Parameters:
IQ_CAP, 16, instruction-queue capacity in entries.
IQ_GAP, 1, entries held back as safety margin.
MAX_OUT, 2, maximum in-flight fetch requests.
RESET_PC, 32'hBFC00000, first fetch address after reset.
IQ_W, $clog2(IQ_CAP)+1, width of the occupancy input.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
SBA_flush_w_i  in  1  branch-unit mispredict flush
SBA_flushPC_i  in  32  correct-path PC for the branch flush
CP0_excOccur_w_i  in  1  exception/eret flush
CP0_excPC_i  in  32  exception/eret target PC
IQ_number_w  in  IQ_W  current IQ occupancy
fetchReq_valid_o  out  1  fetch request valid
fetchReq_ready_i  in  1  I-cache accepts the request
fetchReq_PC_o  out  32  fetch address
IF_respValid_i  in  1  fetch response returns (in order)
IF_predRedirect_i  in  1  response contains a predicted-taken branch
IF_predTarget_i  in  32  predicted target
IQ_writeValid_o  out  1  gated write enable to the IQ (IF_valid_i of the IQ)
IF_outstanding_o  out  $clog2(MAX_OUT+1)  in-flight request count

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=BOOT, fetchReq_valid_o=0, fetchReq_PC_o=RESET_PC, outstanding=0, dropCnt=0, IQ_writeValid_o=0.
- FSM states:
  - BOOT: one cycle, then RUN.
  - RUN: normal operation, dropCnt==0.
  - DRAIN: dropCnt>0. Enter when a redirect leaves dropCnt_next>0; return to RUN when dropCnt_next==0.
- Fire = fetchReq_valid_o && fetchReq_ready_i. On fire, PC <= {PC[31:4]+1, 4'b0}.
- Credit check: fetchReq_valid_o = (state!=BOOT) && !flushAny && outstanding<MAX_OUT && (IQ_number_w + 4*outstanding + 4 <= IQ_CAP - IQ_GAP).
  - Compute in IQ_W+2 bits; no wrap.
  - Credit is conservative: IQ pops in the current cycle are not credited until next cycle.
  - Valid may drop without fire. PC is held stable while valid && !ready.
- Response keep = IF_respValid_i && dropCnt==0 && !flushAny. IQ_writeValid_o = keep, combinational, zero latency.
- Dropped response: dropCnt <= dropCnt-1, unless a flush in the same cycle overrides.
- outstanding_next = outstanding + fire - IF_respValid_i. A response with outstanding==0 is illegal; the bench asserts it never happens.
- Redirect priority: CP0_excOccur_w_i > SBA_flush_w_i > kept predRedirect. flushAny = exc || sba.
  - Flush: PC <= selected target. Fire is forced 0 that cycle. dropCnt <= outstanding - IF_respValid_i, covering all older in-flight responses.
  - Pred redirect (only when keep): PC <= IF_predTarget_i. dropCnt <= outstanding - 1 + fire. A request accepted that same cycle is wrong-path and is also dropped.
- Back-to-back flushes: each recomputes dropCnt from the live outstanding count. The last flush's PC wins.
- Flush during BOOT: PC <= flush target, then RUN.
- Reset mid-operation clears all state asynchronously. In-flight responses after reset release are counted as illegal; the bench must quiesce IF when asserting reset.

Decomposition:
- Shared package/defines: RESET_PC, FETCH_BYTES=16, state encoding (BOOT/RUN/DRAIN), redirect-priority select encoding, and the IQ_CAP/IQ_GAP constants shared with the instruction queue.
- One sub-module: iq_credit_calc, purely combinational, taking IQ_number_w and outstanding and producing the credit-ok flag, so the sizing arithmetic is unit-testable.

Test Plan:
- Reset release, IQ_number_w=0, ready=1: BOOT for 1 cycle, then requests at 0xBFC00000, 0xBFC00010. Valid stops at outstanding=2.
- IQ_number_w=8, outstanding=1 (IQ_CAP=16, IQ_GAP=1): 8+4+4>15, so valid=0. Set IQ_number_w=7: valid=1 next evaluation.
- Two in flight, CP0_excOccur_w_i with CP0_excPC_i=0xBFC00380 and no response that cycle: dropCnt=2. The next two responses give IQ_writeValid_o=0, the third gives 1. First post-flush request PC=0xBFC00380.
- Kept response with IF_predRedirect_i=1, target 0x80001000, plus a request fire in the same cycle with outstanding=1: dropCnt=1, next PC=0x80001000. That response has IQ_writeValid_o=1; the following response has 0.
- CP0_excOccur_w_i and SBA_flush_w_i in the same cycle: PC=CP0_excPC_i. fetchReq_valid_o=0 that cycle.
- ready=0 for 5 cycles with valid=1: PC and valid held stable, outstanding unchanged. On release: 1 fire and PC+16.
